// File: rtl/uart_tx.sv
// uart_tx: UART transmitter fed by a small circular holding FIFO.
// Frames are start(0), DATA_BITS data bits LSB first, optional parity, stop(1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Data_Load,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;
    logic                 can_pop;

    state_t               state;
    state_t               state_next;
    logic [BAUD_W-1:0]    baud;
    logic [BAUD_W-1:0]    baud_next;
    logic [BIT_W-1:0]     bit_idx;
    logic [BIT_W-1:0]     bit_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tx_next;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
    logic                 parity_next;
`endif

    // The transmitter only trusts the registered empty flag, so a fresh load
    // into an empty FIFO waits one extra cycle before the frame starts.
    assign head    = mem[rd_ptr];
    assign can_pop = !FIFO_Empty && (count != '0);
    assign push    = Data_Load && ((count != CNT_FULL) || pop);
    assign Tx_Busy = (state != IDLE);

    // Holding FIFO: storage, wrapping pointers, occupancy and status flags.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_Empty    <= 1'b1;
            FIFO_Full     <= 1'b0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= Tx_Data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            FIFO_Empty <= (count == '0);
            FIFO_Full  <= (count == CNT_FULL);
            if (Data_Load && !push) begin
                FIFO_Overflow <= 1'b1;
            end
        end
    end

    // Frame sequencer: next state, baud timing, bit selection and FIFO pops.
    always_comb begin
        state_next  = state;
        baud_next   = baud + 1'b1;
        bit_next    = bit_idx;
        shift_next  = shift;
        tx_next     = Tx;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        unique case (state)
            IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (can_pop) begin
                    pop         = 1'b1;
                    shift_next  = head;
                    state_next  = START;
                    tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^head;
`endif
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_next   = bit_idx + 1'b1;
                        shift_next = shift >> 1;
                        tx_next    = shift_next[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (can_pop) begin
                        pop         = 1'b1;
                        shift_next  = head;
                        state_next  = START;
                        tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^head;
`endif
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame and parks the line high.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            Tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            baud       <= baud_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            Tx         <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning bits per character.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of transmit holding entries.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 16, meaning Clk cycles per serial bit, legal value >= 2.
REQ-004 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port Tx_Data, input, DATA_BITS bits, the character to queue.
REQ-007 SHALL have port Data_Load, input, 1 bit, a single-cycle write strobe for Tx_Data.
REQ-008 SHALL have port Tx, output, 1 bit, the registered serial line, idle high.
REQ-009 SHALL have port Tx_Busy, output, 1 bit, high while a frame is on the line.
REQ-010 SHALL have port FIFO_Empty, output, 1 bit, high when no entries are held.
REQ-011 SHALL have port FIFO_Full, output, 1 bit, high when FIFO_DEPTH entries are held.
REQ-012 SHALL have port FIFO_Overflow, output, 1 bit, sticky flag for a write that was dropped.

Function
REQ-013 SHALL capture Tx_Data into the FIFO tail on a Clk edge with Data_Load high and FIFO not full.
REQ-014 SHALL drop a Data_Load when the FIFO is full and no pop occurs that cycle, and set FIFO_Overflow, which holds until Rst.
REQ-015 SHALL accept a Data_Load while full if a pop occurs in the same cycle; occupancy is unchanged and FIFO_Overflow is not set.
REQ-016 SHALL use a circular buffer with read and write pointers that wrap at FIFO_DEPTH-1 to 0, plus an occupancy count of 0..FIFO_DEPTH.
REQ-017 SHALL derive FIFO_Empty (count==0) and FIFO_Full (count==FIFO_DEPTH) as registered flags, valid the cycle after the causing edge.
REQ-018 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-019 SHALL, in IDLE with FIFO not empty, pop the head into a shift register and enter START on the next edge, with Tx=0 from that edge.
REQ-020 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a baud counter reloaded at each bit boundary.
REQ-021 SHALL transmit the DATA bits LSB first, DATA_BITS bits in total, with a bit index counting 0..DATA_BITS-1.
REQ-022 SHALL drive Tx=1 in STOP for one bit time.
REQ-023 SHALL, at the end of STOP, go to START with no idle gap if the FIFO is not empty (popping the next entry), else go to IDLE.
REQ-024 SHALL hold Tx_Busy high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-025 SHALL ignore Tx_Data changes after a character has been captured; the frame in flight is never altered.
REQ-026 SHALL handle a Data_Load into an empty FIFO while in IDLE with one cycle of FIFO latency, so START begins 2 edges after the load edge.

Reset
REQ-027 SHALL, on Rst assertion at any time including mid-frame, immediately force: Tx=1, Tx_Busy=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0, state=IDLE, pointers, count, baud counter and bit index = 0.
REQ-028 SHALL clear all FIFO storage to 0 on reset and abort any partial frame without completing it.
REQ-029 SHALL ignore Data_Load while Rst is high, and honour it from the first rising edge after Rst deasserts.

Configuration
REQ-030 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state after DATA driving the even-parity bit (XOR of the data bits) for one bit time.
REQ-031 SHALL, without UART_TX_PARITY_EN, go from DATA directly to STOP with no PARITY state logic present; frame = 1+DATA_BITS+1 bits.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-032 SHALL verify a single write: load 0xA5 in IDLE -> Tx reads 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles long (40 cycles total; with the macro, bit sequence 0,1,0,1,0,0,1,0,1,0,1, 44 cycles), and Tx_Busy is high for exactly that span.
REQ-033 SHALL verify back-to-back frames: load 0x01,0x02,0x03 on consecutive cycles -> three contiguous frames with no idle bit between them, FIFO_Empty=1 after the third pop.
REQ-034 SHALL verify overflow: 6 loads on consecutive cycles while a frame is active -> FIFO_Full=1, FIFO_Overflow=1, and the sixth value is never transmitted.
REQ-035 SHALL verify simultaneous write and pop: a write while full on the STOP->START pop edge -> the write is accepted, FIFO_Overflow stays 0, and the count stays 4.
REQ-036 SHALL verify mid-frame reset: assert Rst during DATA bit 3 -> Tx=1 and Tx_Busy=0 immediately, no further frame, and FIFO_Empty=1.
